// File: rtl/spi_regbank_ctrl_if.sv
// MCU-side SPI pins and board-level register/chip-select outputs of the
// SPI register-bank controller, bundled so the bench and top share one view.
interface spi_regbank_ctrl_if;
  logic       CLK;
  logic       CS;
  logic       MOSI;
  logic       SPECIAL;
  logic [7:0] reg_led;
  logic [7:0] reg_mux;
  logic       adc03_cs;
  logic       frame_err;
  logic [7:0] frame_cnt;

  modport master (
    output CLK, CS, MOSI, SPECIAL,
    input  reg_led, reg_mux, adc03_cs, frame_err, frame_cnt
  );

  modport slave (
    input  CLK, CS, MOSI, SPECIAL,
    output reg_led, reg_mux, adc03_cs, frame_err, frame_cnt
  );
endinterface

// File: rtl/spi_regbank_ctrl.sv
// Oversampled SPI write-frame receiver driving the LED/MUX register bank and
// gating MCU CS onto the ADC03 chip select between transactions only.
module spi_regbank_ctrl #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_LED    = 7,
  parameter int ADDR_MUX    = 8,
  parameter int ADDR_STAT   = 9
) (
  input  logic                XTALCLK,
  input  logic                RESET_N,
  spi_regbank_ctrl_if.slave   bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    COMMIT = 3'd2,
    ABORT  = 3'd3,
    PASS   = 3'd4
  } state_e;

  localparam int                CNT_W   = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_OK  = CNT_W'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q, cs_sync_q, mosi_sync_q, spec_sync_q;
  logic [SYNC_STAGES-1:0] vld_sync_q;
  logic clk_s, cs_s, mosi_s, spec_s, sync_vld;
  logic clk_prev_q, cs_prev_q, spec_prev_q, armed_q;
  logic clk_fall, cs_fall, spec_rise;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            led_q, led_d, mux_q, mux_d, fcnt_q, fcnt_d;
  logic [7:0]            mux_sel_q, mux_sel_d, addr;
  logic                  err_q, err_d;

  always_ff @(posedge XTALCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      spec_sync_q <= '0;
      vld_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      spec_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.CLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      spec_sync_q <= {spec_sync_q[SYNC_STAGES-2:0], bus.SPECIAL};
      vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
      clk_prev_q  <= clk_s;
      cs_prev_q   <= cs_s;
      spec_prev_q <= spec_s;
      // A frame already open when reset releases must not look like a new CS fall.
      armed_q     <= armed_q | (sync_vld & cs_s);
    end
  end

  assign clk_s     = clk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign spec_s    = spec_sync_q[SYNC_STAGES-1];
  assign sync_vld  = vld_sync_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_q & ~clk_s;
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign spec_rise = ~spec_prev_q & spec_s;
  assign addr      = shift_q[FRAME_BITS-1 -: 8];

  always_ff @(posedge XTALCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      mux_q     <= '0;
      fcnt_q    <= '0;
      err_q     <= 1'b0;
      mux_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      mux_q     <= mux_d;
      fcnt_q    <= fcnt_d;
      err_q     <= err_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    mux_d   = mux_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (spec_s) begin
            state_d = PASS;
          end else begin
            state_d = SHIFT;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
      end
      SHIFT: begin
        // The shift happens even on the exit cycle so COMMIT sees the final count.
        if (clk_fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        if (spec_rise)  state_d = ABORT;
        else if (cs_s)  state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == CNT_OK) begin
          if (addr == 8'(ADDR_LED))       led_d = shift_q[7:0];
          else if (addr == 8'(ADDR_MUX))  mux_d = shift_q[7:0];
          else if (addr == 8'(ADDR_STAT)) err_d = 1'b0;
          fcnt_d = fcnt_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
      end
      ABORT: begin
        err_d = 1'b1;
        if (cs_s) state_d = IDLE;
      end
      PASS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing only follows reg_mux between transactions, never mid-frame.
  assign mux_sel_d = (state_q == IDLE && cs_s) ? mux_q : mux_sel_q;

  assign bus.adc03_cs  = (mux_sel_q == 8'd1 && bus.SPECIAL) ? bus.CS : 1'b1;
  assign bus.reg_led   = led_q;
  assign bus.reg_mux   = mux_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = fcnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/spi_regbank_ctrl.md
Name: spi_regbank_ctrl

Overview:
- Synchronous SPI register-bank controller, clocked from XTALCLK.
- Oversamples the MCU SPI pins (CLK, CS, MOSI, SPECIAL), counts and validates 16-bit write frames, and commits address/value pairs to the LED and MUX registers.
- Gates routing of MCU CS onto the ADC03 chip select so a routing change never takes effect mid-transaction.
- Sits between the MCU SPI pins and the board-level LED/peripheral chip-select outputs in top.

Parameters:
- FRAME_BITS, 16, exact bit count of a valid register frame; high byte is address, low byte is value.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2).
- ADDR_LED, 7, register address of reg_led.
- ADDR_MUX, 8, register address of reg_mux.
- ADDR_STAT, 9, writing any value clears frame_err.

Ports:
- XTALCLK  in  1  system clock; must be at least 4x the SPI CLK rate.
- RESET_N  in  1  asynchronous active-low reset.
- CLK  in  1  SPI clock from MCU, idle low, asynchronous.
- CS  in  1  SPI chip select, active low, asynchronous.
- MOSI  in  1  SPI data, MSB first.
- SPECIAL  in  1  0 = register-bank frame; 1 = peripheral passthrough frame.
- reg_led  out  8  LED register.
- reg_mux  out  8  chip-select routing register.
- adc03_cs  out  1  ADC03 chip select, active low.
- frame_err  out  1  sticky flag: a register frame had a bad bit count.
- frame_cnt  out  8  count of committed frames, wraps 255->0.

Behaviour:
- Reset (RESET_N low, asynchronous): reg_led=0, reg_mux=0, frame_err=0, frame_cnt=0, adc03_cs=1, FSM=IDLE, shift register and bit counter cleared, synchronizer flops set to idle levels (CLK=0, CS=1).
- Synchronization: CLK, CS, MOSI and SPECIAL each pass through SYNC_STAGES flops. MOSI is sampled on the synchronized CLK falling edge (previous=1, current=0).
- FSM states:
  - IDLE: CS_s=1. On CS_s fall with SPECIAL_s=0, go to SHIFT (bit counter=0, shift register=0). On CS_s fall with SPECIAL_s=1, go to PASS.
  - SHIFT: on each CLK falling edge, shift MOSI into the LSB and increment the bit counter, saturating at FRAME_BITS+1. If SPECIAL_s rises, go to ABORT. On CS_s rise, go to COMMIT.
  - COMMIT: one cycle, then IDLE.
    - If bit counter == FRAME_BITS: decode the high byte. ADDR_LED writes reg_led; ADDR_MUX writes reg_mux; ADDR_STAT clears frame_err; any other address is ignored. frame_cnt increments for every valid frame, including ignored addresses.
    - Otherwise: set frame_err=1 and write no register.
  - ABORT: set frame_err=1, wait for CS_s=1, then IDLE. Nothing is written.
  - PASS: no shifting. On CS_s rise, go to IDLE.
- Commit latency: register outputs update exactly SYNC_STAGES+2 XTALCLK cycles after the raw CS rising edge (synchronizer delay, plus edge detect, plus COMMIT).
- Routing:
  - mux_sel (internal register) loads reg_mux only while FSM=IDLE and CS_s=1. It is never updated during an open transaction.
  - adc03_cs = CS (raw, combinational) when mux_sel==1 and SPECIAL==1; otherwise 1.
  - A reg_mux write takes effect at the first IDLE cycle after its COMMIT.
- Boundary conditions:
  - CS pulse with zero clocks: count 0, so frame_err=1.
  - 17 or more clocks: counter saturates, so frame_err=1 and no write.
  - CLK falling edge in the same cycle as the CS_s rise: the bit is shifted first, then COMMIT evaluates the updated count.
  - Reset mid-frame: the frame is discarded; nothing is committed after RESET_N releases, and the FSM waits in IDLE for the next CS fall.
  - Write to ADDR_STAT in the same COMMIT that would set the error: cannot occur, because the error path never decodes an address.

Test Plan:
- Reset, then frame 0x0703 (SPECIAL=0) -> reg_led=0x03 exactly SYNC_STAGES+2 cycles after CS rise; frame_cnt=1; frame_err=0.
- Frame 0x0801, then CS low with SPECIAL=1 -> adc03_cs follows CS low/high; with reg_mux=0x02 the same sequence keeps adc03_cs=1.
- 15-bit frame, then a 17-bit frame -> frame_err=1 after each; reg_led/reg_mux unchanged; frame_cnt unchanged; frame 0x0900 then clears frame_err.
- Frame 0x0801 committed while a passthrough would be open -> adc03_cs stays 1 for the current transaction and routes from the next CS fall.
- SPECIAL rises at bit 8 of a register frame -> ABORT, frame_err=1, no register write.
- RESET_N pulsed low at bit 10 of frame 0x07FF -> all outputs 0 / adc03_cs=1; reg_led stays 0 after CS rises; frame_cnt=0.
